// File: rtl/store_buffer.sv
`timescale 1ns/1ps
// store_buffer: posted-write buffer between an SRAM-like CPU port and an AXI
// bridge. Stores are acknowledged as soon as they are queued and drained in
// order; loads go to memory only once the buffer is empty, so a load always
// observes every earlier store without any forwarding logic.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  // CPU side
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic        cpu_uncached,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  // memory (bridge) side
  output logic        mem_req,
  output logic        mem_wr,
  output logic        mem_uncached,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN_REQ,
    DRAIN_WAIT,
    READ_REQ,
    READ_WAIT
  } state_t;

  state_t state, state_nxt;

  // FIFO storage and bookkeeping
  logic [1:0]  size_mem  [DEPTH];
  logic [31:0] addr_mem  [DEPTH];
  logic [31:0] wdata_mem [DEPTH];
  logic        unc_mem   [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;

  // Captured load request, replayed toward memory in READ_REQ
  logic [1:0]  rd_size;
  logic [31:0] rd_addr;
  logic        rd_unc;

  logic wr_ack;
  logic wr_window, push, pop, rd_accept;

  // Handshake decodes. Full is judged on the registered count, so a pop in the
  // same cycle never opens a slot for a push at count == DEPTH.
  always_comb begin
    wr_window = (state == IDLE) || (state == DRAIN_REQ) || (state == DRAIN_WAIT);
    push      = !rst && cpu_req && cpu_wr && (count != CNT_FULL) && wr_window;
    rd_accept = !rst && cpu_req && !cpu_wr && (state == IDLE) && (count == '0);
    pop       = (state == DRAIN_WAIT) && mem_data_ok;
  end

  // State register
  // NOTE: clocked processes use non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and output decode
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    cpu_addr_ok  = push || rd_accept;
    cpu_data_ok  = wr_ack;
    cpu_rdata    = '0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_uncached = 1'b0;
    mem_size     = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    unique case (state)
      IDLE: begin
        if (count != '0)    state_nxt = DRAIN_REQ;
        else if (rd_accept) state_nxt = READ_REQ;
      end
      DRAIN_REQ: begin
        mem_req      = 1'b1;
        mem_wr       = 1'b1;
        mem_uncached = unc_mem[head];
        mem_size     = size_mem[head];
        mem_addr     = addr_mem[head];
        mem_wdata    = wdata_mem[head];
        if (mem_addr_ok) state_nxt = DRAIN_WAIT;
      end
      DRAIN_WAIT: begin
        if (mem_data_ok) state_nxt = IDLE;
      end
      READ_REQ: begin
        mem_req      = 1'b1;
        mem_uncached = rd_unc;
        mem_size     = rd_size;
        mem_addr     = rd_addr;
        if (mem_addr_ok) state_nxt = READ_WAIT;
      end
      READ_WAIT: begin
        if (mem_data_ok) begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = mem_rdata;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pointers, occupancy and the one-cycle write acknowledge. Pointers are
  // log2(DEPTH) bits wide, so incrementing past DEPTH-1 wraps to 0 naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= push;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage written at the tail on every accepted store
  // NOTE: the entry array has no reset; count gates every read of it, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      size_mem[tail]  <= cpu_size;
      addr_mem[tail]  <= cpu_addr;
      wdata_mem[tail] <= cpu_wdata;
      unc_mem[tail]   <= cpu_uncached;
    end
  end

  // Capture the load request on the cycle it is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_size <= '0;
      rd_addr <= '0;
      rd_unc  <= 1'b0;
    end else if (rd_accept) begin
      rd_size <= cpu_size;
      rd_addr <= cpu_addr;
      rd_unc  <= cpu_uncached;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
`timescale 1ns/1ps
// tb_store_buffer: scoreboard bench. Drivers push expected memory requests and
// CPU completions when the DUT accepts a request; a bridge model and a CPU
// monitor pop and compare as the DUT produces them.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0, cpu_uncached = 1'b0;
  logic [1:0]  cpu_size = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_wr, mem_uncached;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_uncached(cpu_uncached),
    .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_uncached(mem_uncached),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        unc;
  } mem_txn_t;

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
    int          acc_cyc;
  } cpu_txn_t;

  mem_txn_t exp_mem[$];
  cpu_txn_t exp_cpu[$];
  int       wr_done_q[$];
  int       rd_done_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- bridge model ----------------
  int          addr_lat = 1;
  int          data_lat = 1;
  bit          addr_hold = 1'b0;
  bit          inject_dok = 1'b0;
  int          req_wait = 0;
  int          data_cnt = 0;
  bit          pend_active = 1'b0;
  bit          pend_wr = 1'b0;
  logic [31:0] pend_rdata = '0;
  logic [31:0] mem_model [logic [31:0]];

  initial begin
    mem_txn_t e;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(posedge clk); #1;
      mem_addr_ok = 1'b0;
      mem_data_ok = inject_dok;
      mem_rdata   = '0;
      if (rst) begin
        req_wait    = 0;
        data_cnt    = 0;
        pend_active = 1'b0;
      end else if (data_cnt > 0) begin
        data_cnt--;
        if (data_cnt == 0) begin
          mem_data_ok = 1'b1;
          mem_rdata   = pend_wr ? 32'h0 : pend_rdata;
        end
      end else if (mem_req && !addr_hold) begin
        if (req_wait >= addr_lat) begin
          mem_addr_ok = 1'b1;
          req_wait    = 0;
        end else begin
          req_wait++;
        end
      end
      @(negedge clk);
      if (!rst) begin
        if (pend_active && data_cnt == 0 && mem_data_ok) begin
          pend_active = 1'b0;
          if (pend_wr) wr_done_q.push_back(cyc);
        end
        if (mem_req && mem_addr_ok) begin
          if (exp_mem.size() == 0) begin
            check("mem_unexpected_req", 1, 0);
          end else begin
            e = exp_mem.pop_front();
            check("mem_addr", mem_addr, e.addr);
            check("mem_wdata", mem_wdata, e.wdata);
            check("mem_attr", {mem_wr, mem_size, mem_uncached}, {e.wr, e.size, e.unc});
          end
          if (mem_wr) mem_model[mem_addr] = mem_wdata;
          pend_rdata  = mem_model.exists(mem_addr) ? mem_model[mem_addr]
                                                   : {16'hA5A5, mem_addr[15:0]};
          pend_wr     = mem_wr;
          pend_active = 1'b1;
          data_cnt    = data_lat;
          req_wait    = 0;
        end
      end
    end
  end

  // ---------------- CPU completion monitor ----------------
  initial begin
    cpu_txn_t c;
    forever begin
      @(negedge clk);
      if (!rst && cpu_data_ok) begin
        if (exp_cpu.size() == 0) begin
          check("cpu_spurious_data_ok", 1, 0);
        end else begin
          c = exp_cpu.pop_front();
          if (c.is_load) begin
            check("load_rdata", cpu_rdata, c.rdata);
            rd_done_q.push_back(cyc);
          end else begin
            check("store_ack_latency", cyc, c.acc_cyc + 1);
          end
        end
      end
    end
  end

  // ---------------- request stability monitor ----------------
  initial begin
    bit          hold_prev = 1'b0;
    logic [67:0] snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev && mem_req)
          check("mem_stable", {mem_wr, mem_size, mem_uncached, mem_addr, mem_wdata}, snap);
        hold_prev = mem_req && !mem_addr_ok;
        snap      = {mem_wr, mem_size, mem_uncached, mem_addr, mem_wdata};
      end
    end
  end

  // ---------------- CPU drivers ----------------
  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input logic unc, output int acc);
    mem_txn_t m;
    cpu_txn_t c;
    cpu_req = 1'b1; cpu_wr = 1'b1;
    cpu_addr = a; cpu_wdata = d; cpu_size = sz; cpu_uncached = unc;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cpu_addr_ok) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      check("store_accept_timeout", 0, 1);
    end else begin
      m = '{wr: 1'b1, size: sz, addr: a, wdata: d, unc: unc};
      exp_mem.push_back(m);
      c = '{is_load: 1'b0, rdata: 32'h0, acc_cyc: acc};
      exp_cpu.push_back(c);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp_data, output int acc);
    mem_txn_t m;
    cpu_txn_t c;
    cpu_req = 1'b1; cpu_wr = 1'b0;
    cpu_addr = a; cpu_wdata = 32'h0; cpu_size = 2'd2; cpu_uncached = 1'b0;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cpu_addr_ok) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      check("load_accept_timeout", 0, 1);
    end else begin
      m = '{wr: 1'b0, size: 2'd2, addr: a, wdata: 32'h0, unc: 1'b0};
      exp_mem.push_back(m);
      c = '{is_load: 1'b1, rdata: exp_data, acc_cyc: acc};
      exp_cpu.push_back(c);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_mem.size() == 0 && exp_cpu.size() == 0 && !pend_active) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check(tag, 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string pre);
    check({pre, "_cpu_hs"}, {cpu_addr_ok, cpu_data_ok}, 0);
    check({pre, "_cpu_rdata"}, cpu_rdata, 0);
    check({pre, "_mem_ctl"}, {mem_req, mem_wr, mem_size, mem_uncached}, 0);
    check({pre, "_mem_addr"}, mem_addr, 0);
    check({pre, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc[5];
    int a0, a1, seen;
    bit got;

    // Reset with an active write presented: everything must stay quiet.
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h5555; cpu_wdata = 32'h1234;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    cpu_req = 1'b0; cpu_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single store, then a load proving the buffer emptied.
    addr_lat = 1; data_lat = 1;
    a0 = cyc;
    do_store(32'h1000, 32'hDEADBEEF, 2'd2, 1'b0, acc[0]);
    check("t1_addr_ok_same_cycle", acc[0], a0);
    wait_quiet("t1_quiet_timeout");
    a0 = cyc;
    do_load(32'h1000, 32'hDEADBEEF, a1);
    check("t1_count_back_to_zero", a1, a0);
    wait_quiet("t1b_quiet_timeout");

    // Five back-to-back stores with the bridge stalled.
    wr_done_q.delete();
    addr_hold = 1'b1; addr_lat = 0; data_lat = 1;
    fork
      for (int k = 0; k < 5; k++)
        do_store(32'(k * 4), 32'h100 + 32'(k), 2'd2, 1'b0, acc[k]);
      begin
        repeat (10) @(negedge clk);
        addr_hold = 1'b0;
      end
    join
    for (int k = 1; k < 4; k++) check("t2_back_to_back", acc[k], acc[k-1] + 1);
    if (wr_done_q.size() > 0) check("t2_fifth_after_pop", acc[4], wr_done_q[0] + 1);
    else check("t2_no_drain_seen", 0, 1);
    wait_quiet("t2_quiet_timeout");

    // Store then load of the same address: load waits for the drain.
    wr_done_q.delete();
    addr_lat = 1; data_lat = 2;
    do_store(32'h2000, 32'h11, 2'd2, 1'b0, a0);
    do_load(32'h2000, 32'h11, a1);
    if (wr_done_q.size() > 0) check("t3_load_after_drain", a1, wr_done_q[0] + 1);
    else check("t3_no_drain_seen", 0, 1);
    wait_quiet("t3_quiet_timeout");

    // Slow load with a store presented meanwhile.
    rd_done_q.delete();
    addr_lat = 0; data_lat = 5;
    do_load(32'h3000, 32'hA5A53000, a0);
    do_store(32'h3004, 32'hCAFE0004, 2'd0, 1'b1, a1);
    if (rd_done_q.size() > 0) check("t4_store_after_load", a1, rd_done_q[0] + 1);
    else check("t4_no_load_done", 0, 1);
    wait_quiet("t4_quiet_timeout");

    // Full buffer with a pop coinciding with a push attempt, mixed attributes,
    // and stray mem_data_ok pulses while a drain request is pending.
    wr_done_q.delete();
    addr_hold = 1'b1; addr_lat = 1; data_lat = 3;
    fork
      for (int k = 0; k < 5; k++)
        do_store(32'h5000 + 32'(k * 8), 32'hF0F0_0000 ^ 32'(k * 32'h111),
                 2'(k % 3), 1'(k & 1), acc[k]);
      begin
        repeat (6) @(negedge clk);
        inject_dok = 1'b1;
        repeat (2) @(negedge clk);
        inject_dok = 1'b0;
        repeat (3) @(negedge clk);
        addr_hold = 1'b0;
      end
    join
    for (int k = 1; k < 4; k++) check("t5_back_to_back", acc[k], acc[k-1] + 1);
    if (wr_done_q.size() > 0) check("t5_push_rejected_on_pop", acc[4], wr_done_q[0] + 1);
    else check("t5_no_drain_seen", 0, 1);
    wait_quiet("t5_quiet_timeout");

    // Reset while a drain is outstanding with three stores buffered.
    addr_hold = 1'b1; addr_lat = 0; data_lat = 40;
    for (int k = 0; k < 3; k++)
      do_store(32'h6000 + 32'(k * 4), 32'h6600 + 32'(k), 2'd2, 1'b0, acc[k]);
    @(negedge clk);
    addr_hold = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pend_active) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("t6_drain_start_timeout", 0, 1);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h6100; cpu_wdata = 32'h77;
    #1 rst = 1'b1;
    #1 check_all_zero("t6_rst");
    exp_mem.delete();
    exp_cpu.delete();
    cpu_req = 1'b0; cpu_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    data_lat = 1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req) seen++;
    end
    check("t6_no_req_after_rst", seen, 0);
    @(posedge clk); #1;
    do_store(32'h7000, 32'h0BADF00D, 2'd1, 1'b1, a0);
    wait_quiet("t6_quiet_timeout");

    check("end_mem_queue_empty", exp_mem.size(), 0);
    check("end_cpu_queue_empty", exp_cpu.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have CPU-side ports cpu_req/cpu_wr/cpu_uncached  input  1 each  SRAM-like request, write flag, uncached attribute.
REQ-005 SHALL have CPU-side ports cpu_size  input  2, cpu_addr  input  32, cpu_wdata  input  32  request size/address/store data.
REQ-006 SHALL have CPU-side ports cpu_addr_ok, cpu_data_ok  output  1 each, cpu_rdata  output  32  handshake and load data.
REQ-007 SHALL have memory-side ports mem_req/mem_wr/mem_uncached  output  1 each, mem_size  output  2, mem_addr/mem_wdata  output  32  request toward the AXI bridge.
REQ-008 SHALL have memory-side ports mem_addr_ok, mem_data_ok  input  1 each, mem_rdata  input  32  bridge handshake and load data.

Function
REQ-009 SHALL hold a DEPTH-entry FIFO, each entry {size, addr, wdata, uncached}, with head/tail pointers and count 0..DEPTH.
REQ-010 SHALL assert cpu_addr_ok combinationally for a write when cpu_req & cpu_wr & count<DEPTH & state in {IDLE, DRAIN_REQ, DRAIN_WAIT}; push on that cycle's edge.
REQ-011 SHALL use the registered count for full: a pop in the same cycle does not admit a push at count==DEPTH.
REQ-012 SHALL assert cpu_data_ok for exactly one cycle, the cycle after each accepted write; cpu_rdata don't-care then.
REQ-013 SHALL implement FSM states IDLE, DRAIN_REQ, DRAIN_WAIT, READ_REQ, READ_WAIT.
REQ-014 IDLE: count>0 -> DRAIN_REQ (priority); else cpu_req & !cpu_wr -> READ_REQ capturing size/addr/uncached and asserting cpu_addr_ok that cycle; else stay.
REQ-015 DRAIN_REQ: mem_req=1, mem_wr=1, mem fields from head entry; on mem_addr_ok -> DRAIN_WAIT.
REQ-016 DRAIN_WAIT: mem_req=0; on mem_data_ok pop head, wrap pointer modulo DEPTH, -> IDLE.
REQ-017 READ_REQ: mem_req=1, mem_wr=0, captured read fields, mem_wdata=0; on mem_addr_ok -> READ_WAIT.
REQ-018 READ_WAIT: on mem_data_ok drive cpu_data_ok=1, cpu_rdata=mem_rdata same cycle, -> IDLE.
REQ-019 SHALL never accept a read while count>0 or a drain is outstanding (read-after-write ordering by full drain, no forwarding).
REQ-020 SHALL not accept writes in READ_REQ/READ_WAIT, so write and read data_ok never coincide.
REQ-021 SHALL keep mem_* request fields stable while mem_req=1 and mem_addr_ok=0.
REQ-022 SHALL allow at most one outstanding memory transaction.
REQ-023 SHALL accept simultaneous push and pop (count unchanged, both pointers advance).
REQ-024 SHALL ignore mem_data_ok outside DRAIN_WAIT/READ_WAIT.

Reset
REQ-025 On rst=1, SHALL immediately set state=IDLE, count=0, head=tail=0, write-ack register=0.
REQ-026 During reset, SHALL drive cpu_addr_ok=0, cpu_data_ok=0, cpu_rdata=0, mem_req=0, mem_wr=0, mem_size=0, mem_addr=0, mem_wdata=0, mem_uncached=0.
REQ-027 Reset mid-transaction SHALL discard all buffered stores and the outstanding request without completing them.

Verification
REQ-028 Single store 0x1000<-0xDEADBEEF, bridge addr_ok/data_ok after 1 cycle -> cpu_addr_ok same cycle, cpu_data_ok next cycle, mem_addr=0x1000, mem_wdata=0xDEADBEEF, mem_wr=1, count returns to 0.
REQ-029 Five back-to-back stores, mem_addr_ok held 0 -> first four accepted, fifth sees cpu_addr_ok=0 until first drain pops; memory order 0x0,0x4,0x8,0xC,0x10.
REQ-030 Store 0x2000<-0x11 then load 0x2000 -> load accepted only after store's mem_data_ok; cpu_rdata=mem_rdata=0x11, single cpu_data_ok for load.
REQ-031 Load with mem_data_ok delayed 5 cycles, CPU presents store meanwhile -> store cpu_addr_ok=0 until load cpu_data_ok, then accepted next IDLE cycle.
REQ-032 Push at count==DEPTH coinciding with pop -> push rejected that cycle, accepted next cycle; pointers wrap 3->0 correctly.
REQ-033 rst asserted in DRAIN_WAIT with count=3 -> all outputs 0 immediately, after release no mem_req until new store.
